// File: rtl/cache_traffic_gen.sv
// rtl/cache_traffic_gen.sv - CPU-port traffic generator with hit/miss statistics (optional watchdog: TRAFFIC_TIMEOUT_EN)
module cache_traffic_gen #(
  parameter int unsigned          ADDR_W         = 32,
  parameter int unsigned          DATA_W         = 512,
  parameter int unsigned          CNT_W          = 32,
  parameter logic [31:0]          LFSR_SEED      = 32'hACE12468,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  num_accesses_i,
  input  logic [7:0]        write_pct_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] region_mask_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              cpu_read_o,
  output logic              cpu_write_o,
  output logic [ADDR_W-1:0] cpu_address_o,
  output logic [DATA_W-1:0] cpu_write_data_o,
  input  logic              cache_hit_i,
  input  logic              cache_miss_i,
  input  logic              done_signal_i,
  output logic              busy_o,
  output logic              finished_o,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o,
  output logic              timeout_err_o
);

  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] TAPS = 32'h80200003;

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT_DONE, GAP, FIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              is_write_q, is_write_d;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  num_q, idx_q, idx_inc;
  logic [7:0]        wpct_q;
  logic [ADDR_W-1:0] base_q, mask_q, stride_q, stride_acc_q;
  logic [CNT_W-1:0]  hit_q, miss_q;
  logic              finished_q, counted_q, abort_seen_q;
  logic              req_active, wdog_expire;
  logic [ADDR_W-1:0] lfsr_ext;

  assign req_active       = (state_q == ISSUE) || (state_q == WAIT_DONE);
  assign cpu_read_o       = req_active && !is_write_q;
  assign cpu_write_o      = req_active && is_write_q;
  assign cpu_address_o    = addr_q;
  assign cpu_write_data_o = data_q;
  assign busy_o           = (state_q != IDLE) && (state_q != FIN);
  assign finished_o       = finished_q;
  assign hit_count_o      = hit_q;
  assign miss_count_o     = miss_q;
  assign idx_inc          = idx_q + CNT_W'(1);

`ifdef TRAFFIC_TIMEOUT_EN
  logic [31:0] wdog_q;
  logic        timeout_err_q;

  assign wdog_expire   = req_active && !done_signal_i && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err_o = timeout_err_q;

  // Watchdog: counts request cycles of the current access; error is sticky until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == SETUP)   wdog_q <= '0;
      else if (req_active)    wdog_q <= wdog_q + 32'd1;
      if (state_q == IDLE && start_i) timeout_err_q <= 1'b0;
      else if (wdog_expire)           timeout_err_q <= 1'b1;
    end
  end
`else
  assign wdog_expire   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // Next LFSR value, address, write select and write data for the access being set up.
  always_comb begin
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
    lfsr_ext = ADDR_W'(lfsr_d);
    case (mode_q)
      2'd1:    addr_d = base_q + (lfsr_ext & mask_q);
      2'd2:    addr_d = base_q + stride_acc_q;
      default: addr_d = lfsr_ext;
    endcase
    is_write_d = ({1'b0, lfsr_d[31:25]} < wpct_q);
    data_d = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      data_d[k*32 +: 32] = lfsr_d + 32'(k);
    end
  end

  // FSM next state: one access per SETUP/ISSUE/WAIT_DONE/GAP loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (num_accesses_i == '0) ? FIN : SETUP;
      SETUP: state_d = ISSUE;
      ISSUE, WAIT_DONE: begin
        if (done_signal_i)    state_d = GAP;
        else if (wdog_expire) state_d = FIN;
        else                  state_d = WAIT_DONE;
      end
      GAP:   state_d = ((idx_inc == num_q) || abort_seen_q || abort_i) ? FIN : SETUP;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath: run configuration, LFSR, request registers, index and statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q       <= SEED;
      addr_q       <= '0;
      data_q       <= '0;
      is_write_q   <= 1'b0;
      mode_q       <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      wpct_q       <= '0;
      base_q       <= '0;
      mask_q       <= '0;
      stride_q     <= '0;
      stride_acc_q <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      finished_q   <= 1'b0;
      counted_q    <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          mode_q       <= mode_i;
          num_q        <= num_accesses_i;
          wpct_q       <= write_pct_i;
          base_q       <= base_addr_i;
          mask_q       <= region_mask_i;
          stride_q     <= stride_i;
          stride_acc_q <= '0;
          idx_q        <= '0;
          hit_q        <= '0;
          miss_q       <= '0;
          finished_q   <= 1'b0;
          abort_seen_q <= 1'b0;
        end
        SETUP: begin
          lfsr_q     <= lfsr_d;
          addr_q     <= addr_d;
          data_q     <= data_d;
          is_write_q <= is_write_d;
          counted_q  <= 1'b0;
        end
        ISSUE, WAIT_DONE: begin
          // Only the first hit/miss cycle of an access is counted; hit+miss together is a miss.
          if (!counted_q && (cache_hit_i || cache_miss_i)) begin
            counted_q <= 1'b1;
            if (cache_miss_i) begin
              if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
            end else begin
              if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
            end
          end
        end
        GAP: begin
          idx_q        <= idx_inc;
          stride_acc_q <= stride_acc_q + stride_q;
        end
        FIN: finished_q <= 1'b1;
        default: ;
      endcase
      if (busy_o && abort_i) abort_seen_q <= 1'b1;
    end
  end

endmodule
